ghost_mode_scheduler: RTL and testbench

GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

---
 rtl/pacman_pkg.sv | 41 ++++
 rtl/ghost_mode_scheduler_if.sv | 38 +++
 rtl/frame_timer.sv | 41 ++++
 rtl/ghost_mode_scheduler.sv | 174 +++++++++++++++++
 tb/tb_ghost_mode_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pacman_pkg
// Description : Shared Pac-Man types and constants: ghost mode encoding,
//               ghost direction encoding, frame counter width and the
//               default schedule / frightened durations (in 60 Hz frames).
// Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

    localparam int c_cnt_w = 11;

    // Ghost behaviour mode as seen on the mode output
    typedef enum logic [1:0] {
        MODE_SCATTER = 2'b00,
        MODE_CHASE   = 2'b01,
        MODE_FRIGHT  = 2'b10,
        MODE_IDLE    = 2'b11
    } mode_e;

    // Ghost heading
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    localparam int c_scatter_long_def  = 420;
    localparam int c_scatter_short_def = 300;
    localparam int c_chase_len_def     = 1200;
    localparam int c_fright_len_def    = 360;
    localparam int c_flash_len_def     = 120;

    // Even schedule phases scatter, odd phases chase
    function automatic mode_e sched_mode(input logic [2:0] ph);
        return ph[0] ? MODE_CHASE : MODE_SCATTER;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_mode_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ghost_mode_scheduler_if
// Description : Control/status bundle of the ghost mode scheduler.
//               master : game logic (drives start, pause, power_pellet)
//               slave  : scheduler  (drives mode, phase, reverse, flash)
//               start        - begin schedule (level, honoured in IDLE only)
//               pause        - freeze everything while high
//               power_pellet - one-cycle energizer pulse
//               mode[1:0]    - SCATTER=00 CHASE=01 FRIGHT=10 IDLE=11
//               phase[2:0]   - schedule index 0..7
//               reverse      - one-cycle reverse-direction command
//               flash        - frightened mode is about to end
// Revision    : 1.0 - initial release
// ============================================================================
interface ghost_mode_scheduler_if;
    import pacman_pkg::*;

    logic       start;
    logic       pause;
    logic       power_pellet;
    logic [1:0] mode;
    logic [2:0] phase;
    logic       reverse;
    logic       flash;

    modport master (
        output start, pause, power_pellet,
        input  mode, phase, reverse, flash
    );

    modport slave (
        input  start, pause, power_pellet,
        output mode, phase, reverse, flash
    );

endinterface
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Frame counter with enable and synchronous clear. done is
//               high while count equals the terminal value term. The counter
//               wraps; the owner gates en if it must saturate.
//               clk60 - frame clock      reset - sync active-high reset
//               en    - count this frame clr   - force count to zero
//               term  - terminal count   count - current count
//               done  - count == term
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer
    import pacman_pkg::*;
#(
    parameter int WIDTH = c_cnt_w
) (
    input  wire logic             clk60,
    input  wire logic             reset,
    input  wire logic             en,
    input  wire logic             clr,
    input  wire logic [WIDTH-1:0] term,
    output logic      [WIDTH-1:0] count,
    output logic                  done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk60) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign done  = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/ghost_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ghost_mode_scheduler
// Description : Arcade ghost scatter/chase schedule with frightened-mode
//               overlay. Eight schedule phases (7 = chase forever); an
//               energizer freezes the schedule, enters FRIGHT and the
//               schedule resumes exactly where it stopped afterwards.
//               clk60 - 60 Hz frame clock   reset - sync active-high reset
//               bus   - ghost_mode_scheduler_if.slave (start, pause,
//                       power_pellet in; mode, phase, reverse, flash out)
// Revision    : 1.0 - initial release
// ============================================================================
module ghost_mode_scheduler
    import pacman_pkg::*;
#(
    parameter int SCATTER_LONG  = c_scatter_long_def,
    parameter int SCATTER_SHORT = c_scatter_short_def,
    parameter int CHASE_LEN     = c_chase_len_def,
    parameter int FRIGHT_LEN    = c_fright_len_def,
    parameter int FLASH_LEN     = c_flash_len_def
) (
    input  wire logic              clk60,
    input  wire logic              reset,
    ghost_mode_scheduler_if.slave  bus
);

    // Zero-length phases would never reach their terminal count
    if (SCATTER_LONG <= 0 || SCATTER_SHORT <= 0 || CHASE_LEN <= 0 || FRIGHT_LEN <= 0) begin : g_chk_zero_duration
        $error("ghost_mode_scheduler: durations must be non-zero");
    end
    if (SCATTER_LONG > 2047 || SCATTER_SHORT > 2047 || CHASE_LEN > 2047 || FRIGHT_LEN > 2047) begin : g_chk_width
        $error("ghost_mode_scheduler: durations must fit the 11-bit counters");
    end
    if (FLASH_LEN < 0 || FLASH_LEN > FRIGHT_LEN) begin : g_chk_flash
        $error("ghost_mode_scheduler: FLASH_LEN must lie within FRIGHT_LEN");
    end

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_sched  = 2'd1;
    localparam logic [1:0] c_st_fright = 2'd2;

    localparam logic [c_cnt_w-1:0] c_sl_term  = c_cnt_w'(SCATTER_LONG - 1);
    localparam logic [c_cnt_w-1:0] c_ss_term  = c_cnt_w'(SCATTER_SHORT - 1);
    localparam logic [c_cnt_w-1:0] c_ch_term  = c_cnt_w'(CHASE_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_fr_term  = c_cnt_w'(FRIGHT_LEN - 1);
    localparam logic [c_cnt_w-1:0] c_flash_th = c_cnt_w'(FRIGHT_LEN - FLASH_LEN);
    localparam logic [c_cnt_w-1:0] c_cnt_max  = '1;

    logic [1:0]         r_state;
    logic [2:0]         r_phase;
    mode_e              r_mode;
    logic               r_reverse;
    logic               r_flash;

    logic [c_cnt_w-1:0] w_sched_term;
    logic [c_cnt_w-1:0] w_sched_cnt;
    logic [c_cnt_w-1:0] w_fright_cnt;
    logic               w_sched_done;
    logic               w_fright_done;
    logic               w_boundary;
    logic               w_sched_en;
    logic               w_sched_clr;
    logic               w_fright_en;
    logic               w_fright_clr;
    logic [2:0]         w_next_phase;

    // Per-phase terminal count; phase 7 never terminates
    always_comb begin
        w_sched_term = c_cnt_max;
        case (r_phase)
            3'd0, 3'd2:       w_sched_term = c_sl_term;
            3'd1, 3'd3, 3'd5: w_sched_term = c_ch_term;
            3'd4, 3'd6:       w_sched_term = c_ss_term;
            default:          w_sched_term = c_cnt_max;
        endcase
    end

    assign w_next_phase = r_phase + 3'd1;
    assign w_boundary   = (r_state == c_st_sched) && w_sched_done && (r_phase != 3'd7);

    // A pellet freezes the schedule counter, and beats a phase boundary.
    // In phase 7 the counter stops at all-ones instead of wrapping.
    assign w_sched_en  = !bus.pause && (r_state == c_st_sched) && !bus.power_pellet
                         && !w_boundary && (w_sched_cnt != c_cnt_max);
    assign w_sched_clr = !bus.pause &&
                         (((r_state == c_st_idle) && bus.start) ||
                          ((r_state == c_st_sched) && !bus.power_pellet && w_boundary));

    assign w_fright_en  = !bus.pause && (r_state == c_st_fright);
    assign w_fright_clr = !bus.pause &&
                          (((r_state == c_st_sched) && bus.power_pellet) ||
                           ((r_state == c_st_fright) && (bus.power_pellet || w_fright_done)));

    frame_timer #(.WIDTH(c_cnt_w)) u_sched_timer (
        .clk60 (clk60),
        .reset (reset),
        .en    (w_sched_en),
        .clr   (w_sched_clr),
        .term  (w_sched_term),
        .count (w_sched_cnt),
        .done  (w_sched_done)
    );

    frame_timer #(.WIDTH(c_cnt_w)) u_fright_timer (
        .clk60 (clk60),
        .reset (reset),
        .en    (w_fright_en),
        .clr   (w_fright_clr),
        .term  (c_fr_term),
        .count (w_fright_cnt),
        .done  (w_fright_done)
    );

    always_ff @(posedge clk60) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_phase   <= 3'd0;
            r_mode    <= MODE_IDLE;
            r_reverse <= 1'b0;
            r_flash   <= 1'b0;
        end else if (bus.pause) begin
            r_reverse <= 1'b0;
        end else begin
            r_reverse <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_flash <= 1'b0;
                    if (bus.start) begin
                        r_state <= c_st_sched;
                        r_phase <= 3'd0;
                        r_mode  <= MODE_SCATTER;
                    end
                end
                c_st_sched: begin
                    if (bus.power_pellet) begin
                        r_state   <= c_st_fright;
                        r_mode    <= MODE_FRIGHT;
                        r_reverse <= 1'b1;
                        r_flash   <= (c_flash_th == '0);
                    end else if (w_boundary) begin
                        r_phase   <= w_next_phase;
                        r_mode    <= sched_mode(w_next_phase);
                        r_reverse <= 1'b1;
                    end
                end
                c_st_fright: begin
                    if (bus.power_pellet) begin
                        r_flash <= 1'b0;
                    end else if (w_fright_done) begin
                        r_state <= c_st_sched;
                        r_mode  <= sched_mode(r_phase);
                        r_flash <= 1'b0;
                    end else begin
                        // Registered flash tracks the count it will see next frame
                        r_flash <= ((w_fright_cnt + 1'b1) >= c_flash_th);
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_phase <= 3'd0;
                    r_mode  <= MODE_IDLE;
                    r_flash <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mode    = r_mode;
    assign bus.phase   = r_phase;
    assign bus.reverse = r_reverse;
    assign bus.flash   = r_flash;

endmodule
`default_nettype wire

// File: tb/tb_ghost_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ghost_mode_scheduler
// Description : Directed self-checking bench for ghost_mode_scheduler with
//               default durations (420/300/1200/360/120 frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_mode_scheduler;
    import pacman_pkg::*;

    logic clk60 = 1'b0;
    logic reset;
    int   checks  = 0;
    int   errors  = 0;
    int   rev_cnt = 0;
    int   bad_cnt = 0;

    ghost_mode_scheduler_if bus();

    ghost_mode_scheduler dut (
        .clk60 (clk60),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk60 = ~clk60;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk60);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.reverse === 1'b1) rev_cnt++;
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.pause        = 1'b0;
        bus.power_pellet = 1'b0;
        tick();
        tick();
        chk("reset_mode",    32'(bus.mode),    32'd3);
        chk("reset_phase",   32'(bus.phase),   32'd0);
        chk("reset_reverse", 32'(bus.reverse), 32'd0);
        chk("reset_flash",   32'(bus.flash),   32'd0);

        // Pellet in IDLE is ignored
        reset = 1'b0;
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        tick();
        chk("idle_pellet_mode", 32'(bus.mode),    32'd3);
        chk("idle_pellet_rev",  32'(bus.reverse), 32'd0);

        // Start, then phase 0 lasts 420 frames
        bus.start = 1'b1;
        tick();
        chk("start_mode",  32'(bus.mode),    32'd0);
        chk("start_phase", 32'(bus.phase),   32'd0);
        chk("start_rev",   32'(bus.reverse), 32'd0);
        rev_cnt = 0;
        run(419);   // start stays high: ignored outside IDLE
        bus.start = 1'b0;
        chk("p0_end_phase", 32'(bus.phase), 32'd0);
        chk("p0_end_mode",  32'(bus.mode),  32'd0);
        chk("p0_end_revs",  32'(rev_cnt),   32'd0);
        tick();
        chk("p1_phase", 32'(bus.phase),   32'd1);
        chk("p1_mode",  32'(bus.mode),    32'd1);
        chk("p1_rev",   32'(bus.reverse), 32'd1);
        tick();
        chk("p1_rev_pulse", 32'(bus.reverse), 32'd0);

        // Rest of the schedule up to phase 4, then phase 7
        rev_cnt = 0;
        run(2819);
        chk("p4_phase", 32'(bus.phase),   32'd4);
        chk("p4_mode",  32'(bus.mode),    32'd0);
        chk("p4_rev",   32'(bus.reverse), 32'd1);
        run(1800);
        chk("p7_phase", 32'(bus.phase), 32'd7);
        chk("p7_mode",  32'(bus.mode),  32'd1);
        chk("p7_revs",  32'(rev_cnt),   32'd6);

        // Phase 7 holds forever
        rev_cnt = 0;
        bad_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (bus.reverse !== 1'b0) rev_cnt++;
            if (bus.phase !== 3'd7 || bus.mode !== 2'b01) bad_cnt++;
        end
        chk("hold_revs",  32'(rev_cnt), 32'd0);
        chk("hold_bad",   32'(bad_cnt), 32'd0);

        // Pellet at sched_cnt=100 of phase 0
        restart();
        run(100);
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        chk("fr_mode",  32'(bus.mode),    32'd2);
        chk("fr_rev",   32'(bus.reverse), 32'd1);
        chk("fr_flash", 32'(bus.flash),   32'd0);
        chk("fr_phase", 32'(bus.phase),   32'd0);
        rev_cnt = 0;
        run(239);
        chk("fr_flash_239", 32'(bus.flash), 32'd0);
        run(1);
        chk("fr_flash_240", 32'(bus.flash), 32'd1);
        run(119);
        chk("fr_mode_359", 32'(bus.mode), 32'd2);
        run(1);
        chk("fr_exit_mode",  32'(bus.mode),  32'd0);
        chk("fr_exit_flash", 32'(bus.flash), 32'd0);
        chk("fr_exit_revs",  32'(rev_cnt),   32'd0);
        run(319);
        chk("fr_resume_p0", 32'(bus.phase), 32'd0);
        tick();
        chk("fr_resume_p1",  32'(bus.phase),   32'd1);
        chk("fr_resume_rev", 32'(bus.reverse), 32'd1);

        // Second pellet at fright_cnt=300
        restart();
        run(10);
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        run(300);
        chk("re_flash_300", 32'(bus.flash), 32'd1);
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        chk("re_flash_drop", 32'(bus.flash),   32'd0);
        chk("re_no_rev",     32'(bus.reverse), 32'd0);
        chk("re_mode",       32'(bus.mode),    32'd2);
        rev_cnt = 0;
        run(359);
        chk("re_mode_359", 32'(bus.mode), 32'd2);
        run(1);
        chk("re_exit_mode", 32'(bus.mode), 32'd0);
        chk("re_exit_revs", 32'(rev_cnt),  32'd0);

        // Pause 50 frames mid-FRIGHT with an ignored pellet
        restart();
        run(5);
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        run(100);
        rev_cnt = 0;
        bus.pause = 1'b1;
        run(20);
        bus.power_pellet = 1'b1;
        run(1);
        bus.power_pellet = 1'b0;
        run(29);
        chk("pz_mode",  32'(bus.mode),  32'd2);
        chk("pz_flash", 32'(bus.flash), 32'd0);
        chk("pz_revs",  32'(rev_cnt),   32'd0);
        bus.pause = 1'b0;
        run(139);
        chk("pz_flash_239", 32'(bus.flash), 32'd0);
        run(1);
        chk("pz_flash_240", 32'(bus.flash), 32'd1);
        run(119);
        chk("pz_mode_359", 32'(bus.mode), 32'd2);
        run(1);
        chk("pz_exit_mode", 32'(bus.mode), 32'd0);

        // Pellet exactly on the 420th frame of phase 0
        restart();
        run(419);
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        chk("edge_mode",  32'(bus.mode),    32'd2);
        chk("edge_phase", 32'(bus.phase),   32'd0);
        chk("edge_rev",   32'(bus.reverse), 32'd1);
        rev_cnt = 0;
        run(359);
        chk("edge_revs", 32'(rev_cnt), 32'd0);
        run(1);
        chk("edge_exit_mode",  32'(bus.mode),  32'd0);
        chk("edge_exit_phase", 32'(bus.phase), 32'd0);
        tick();
        chk("edge_adv_phase", 32'(bus.phase),   32'd1);
        chk("edge_adv_rev",   32'(bus.reverse), 32'd1);

        // Reset mid-FRIGHT beats pause and pellet
        bus.power_pellet = 1'b1;
        tick();
        bus.power_pellet = 1'b0;
        run(5);
        reset = 1'b1;
        bus.pause = 1'b1;
        bus.power_pellet = 1'b1;
        tick();
        chk("rst_fr_mode",  32'(bus.mode),    32'd3);
        chk("rst_fr_phase", 32'(bus.phase),   32'd0);
        chk("rst_fr_flash", 32'(bus.flash),   32'd0);
        chk("rst_fr_rev",   32'(bus.reverse), 32'd0);
        reset = 1'b0;
        bus.power_pellet = 1'b0;
        bus.start = 1'b1;
        tick();
        chk("pause_start_mode", 32'(bus.mode), 32'd3);
        bus.pause = 1'b0;
        tick();
        bus.start = 1'b0;
        chk("unpause_start_mode", 32'(bus.mode), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
